// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS pipeline stages.
//   pc_src_t      - next-PC select encoding driven by the ID stage.
//   fetch_state_t - states of the fetch-stage request controller.
//   NOP_INSTR     - all-zero word used as the pipeline bubble.
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden.
package mips_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    DRAIN = 2'b01,
    STALL = 2'b10
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst      - clock and synchronous active-high reset.
//   write_en      - 1 updates the register, 0 holds every output.
//   flush         - when writing, insert a bubble regardless of load.
//   load          - when writing without flush, capture instr_in/pc_plus4_in.
//   instr_in, pc_plus4_in - delivered instruction and its return address.
//   instr, pc_plus4, valid - registered outputs toward ID.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // A bubble only clears instr/valid; pc_plus4 keeps its last value since
  // nothing downstream looks at it while valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= 32'h0000_0000;
      valid    <= 1'b0;
    end else if (write_en) begin
      if (flush || !load) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end else begin
        instr    <= instr_in;
        pc_plus4 <= pc_plus4_in;
        valid    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, requests instructions
// from a variable-latency memory over req/ready, and feeds the IF/ID register.
//   clk, rst          - clock and synchronous active-high reset.
//   pc_write          - 1 lets the PC advance or redirect.
//   IF_ID_write       - 1 lets the IF/ID register update.
//   pc_src            - 00 seq, 01 branch_target, 10 jump_target, 11 jr_target.
//   branch_target, jump_target, jr_target - redirect addresses from ID.
//   if_flush          - write a bubble into IF/ID.
//   imem_req/imem_addr/imem_ready/imem_rdata - instruction memory handshake.
//   pc                - current fetch PC.
//   IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid - IF/ID register outputs.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        IF_ID_write,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        if_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc_plus4,
  output logic        IF_ID_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  redir_q, redir_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redirect;
  logic         completion;
  logic         deliver;
  logic [31:0]  deliver_instr;

  // Request is a pure decode of registered state; rst only withdraws it.
  assign imem_req   = !rst && (state_q != STALL);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign completion = imem_req && imem_ready;

  always_comb begin
    target   = pc_plus4;
    redirect = 1'b0;
    case (pc_src_t'(pc_src))
      PC_BRANCH: target = branch_target;
      PC_JUMP:   target = jump_target;
      PC_JR:     target = jr_target;
      default:   target = pc_plus4;
    endcase
    redirect = pc_write && (pc_src != PC_SEQ);
  end

  // A response that arrives alongside (or after) a redirect is stale and is
  // dropped; DRAIN exists only to swallow the in-flight request.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    redir_d       = redir_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    case (state_q)
      FETCH: begin
        if (completion) begin
          if (redirect) begin
            pc_d = target;
          end else if (IF_ID_write) begin
            deliver = 1'b1;
            if (pc_write) pc_d = pc_plus4;
          end else begin
            hold_d  = imem_rdata;
            state_d = STALL;
          end
        end else if (redirect) begin
          redir_d = target;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect) redir_d = target;
        if (completion) begin
          pc_d    = redirect ? target : redir_q;
          state_d = FETCH;
        end
      end
      STALL: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (IF_ID_write) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          if (pc_write) pc_d = pc_plus4;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0000_0000;
      redir_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      redir_q <= redir_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .write_en    (IF_ID_write),
    .flush       (if_flush),
    .load        (deliver),
    .instr_in    (deliver_instr),
    .pc_plus4_in (pc_plus4),
    .instr       (IF_ID_instr),
    .pc_plus4    (IF_ID_pc_plus4),
    .valid       (IF_ID_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by random stall/redirect/wait
// traffic on fetch_stage, compared against a transaction-level model of the
// fetch rules. A second instance with RESET_PC = 32'hFFFF_FFFC runs zero-wait
// to exercise PC wrap-around.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        IF_ID_write = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] branch_target = 32'h0000_0040;
  logic [31:0] jump_target = 32'h0000_0100;
  logic [31:0] jr_target = 32'h0000_0200;
  logic        if_flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc_plus4;
  logic        IF_ID_valid;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic [31:0] w_pc;
  logic [31:0] w_IF_ID_instr;
  logic [31:0] w_IF_ID_pc_plus4;
  logic        w_IF_ID_valid;

  localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFFC;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the fetch PC, an optional held response, an optional
  // pending redirect target, and the expected IF/ID contents.
  logic [31:0] m_pc = 32'h0000_0000;
  logic [31:0] held_q[$];
  logic [31:0] redir_q[$];
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pp4 = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] mw_pc = WRAP_RESET_PC;
  logic [31:0] mw_instr = 32'h0;
  logic [31:0] mw_pp4 = 32'h0;
  logic        mw_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign w_imem_rdata = mem_word(w_imem_addr);

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .IF_ID_write    (IF_ID_write),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .jr_target      (jr_target),
    .if_flush       (if_flush),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_pc_plus4 (IF_ID_pc_plus4),
    .IF_ID_valid    (IF_ID_valid)
  );

  fetch_stage #(.RESET_PC(WRAP_RESET_PC)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (1'b1),
    .IF_ID_write    (1'b1),
    .pc_src         (2'b00),
    .branch_target  (32'h0),
    .jump_target    (32'h0),
    .jr_target      (32'h0),
    .if_flush       (1'b0),
    .imem_req       (w_imem_req),
    .imem_addr      (w_imem_addr),
    .imem_ready     (1'b1),
    .imem_rdata     (w_imem_rdata),
    .pc             (w_pc),
    .IF_ID_instr    (w_IF_ID_instr),
    .IF_ID_pc_plus4 (w_IF_ID_pc_plus4),
    .IF_ID_valid    (w_IF_ID_valid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT is about to see.
  task automatic modelUpdate(input logic req);
    logic [31:0] tgt;
    logic [31:0] old_pc;
    logic        redirect, comp, deliver;
    logic [31:0] d_instr;
    if (rst) begin
      m_pc = 32'h0; held_q.delete(); redir_q.delete();
      m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      mw_pc = WRAP_RESET_PC; mw_instr = 32'h0; mw_pp4 = 32'h0; mw_valid = 1'b0;
      return;
    end
    mw_instr = mem_word(mw_pc); mw_pp4 = mw_pc + 32'd4; mw_valid = 1'b1;
    mw_pc = mw_pc + 32'd4;

    tgt = (pc_src == 2'd1) ? branch_target : (pc_src == 2'd2) ? jump_target : jr_target;
    redirect = pc_write && (pc_src != 2'd0);
    comp = req && imem_ready;
    old_pc = m_pc;
    deliver = 1'b0;
    d_instr = 32'h0;
    if (held_q.size() != 0) begin
      if (redirect) begin
        held_q.delete(); m_pc = tgt;
      end else if (IF_ID_write) begin
        deliver = 1'b1; d_instr = held_q.pop_front();
        if (pc_write) m_pc = old_pc + 32'd4;
      end
    end else if (redir_q.size() != 0) begin
      if (redirect) redir_q[0] = tgt;
      if (comp) begin
        m_pc = redir_q.pop_front();
      end
    end else if (comp) begin
      if (redirect) m_pc = tgt;
      else if (IF_ID_write) begin
        deliver = 1'b1; d_instr = mem_word(old_pc);
        if (pc_write) m_pc = old_pc + 32'd4;
      end else held_q.push_back(mem_word(old_pc));
    end else if (redirect) begin
      redir_q.push_back(tgt);
    end

    if (IF_ID_write) begin
      if (if_flush || !deliver) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = d_instr; m_pp4 = old_pc + 32'd4; m_valid = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic pw, input logic iw,
                               input logic [1:0] src, input logic fl, input logic rdy);
    logic exp_req;
    @(negedge clk);
    rst = r; pc_write = pw; IF_ID_write = iw; pc_src = src; if_flush = fl; imem_ready = rdy;
    #1;
    exp_req = !r && (held_q.size() == 0);
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("pc", pc, m_pc);
    checkOutput("wrap_req", {31'b0, w_imem_req}, {31'b0, !r});
    checkOutput("wrap_addr", w_imem_addr, mw_pc);
    modelUpdate(exp_req);
    @(posedge clk);
    #1;
    checkOutput("IF_ID_instr", IF_ID_instr, m_instr);
    checkOutput("IF_ID_pc_plus4", IF_ID_pc_plus4, m_pp4);
    checkOutput("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
    checkOutput("wrap_IF_ID_pc_plus4", w_IF_ID_pc_plus4, mw_pp4);
    checkOutput("wrap_IF_ID_valid", {31'b0, w_IF_ID_valid}, {31'b0, mw_valid});
  endtask

  initial begin
    logic r, pw, iw, fl, rdy;
    logic [1:0] src;
    $display("[TB] starting fetch_stage bench");
    @(posedge clk);

    // Reset then zero-wait streaming.
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 1, 1, 0, 0, 1);

    // Load-use stall with the response arriving while frozen.
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 1);

    // Taken branch with flush under zero-wait memory.
    applyStimulus(0, 1, 1, 1, 1, 1);
    repeat (5) applyStimulus(0, 1, 1, 0, 0, 1);

    // Jump during a wait, then a second redirect while draining.
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 2, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 3, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 1);

    // Reset while draining.
    applyStimulus(0, 1, 1, 2, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 1);
    repeat (3) applyStimulus(0, 1, 1, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      branch_target = $urandom & 32'hFFFF_FFFC;
      jump_target   = $urandom & 32'hFFFF_FFFC;
      jr_target     = $urandom & 32'hFFFF_FFFC;
      r   = ($urandom_range(0, 59) == 0);
      pw  = ($urandom_range(0, 9) < 8);
      iw  = ($urandom_range(0, 9) < 8);
      src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      fl  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      applyStimulus(r, pw, iw, src, fl, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, issues requests to a variable-latency instruction memory over a req/ready handshake, and drives the IF/ID pipeline register. It sits directly upstream of the ID stage and its hazard unit. It obeys the hazard unit's `pc_write`/`IF_ID_write` stall outputs, applies taken-branch/jump redirects resolved in ID, and inserts bubbles on flush.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_write` in 1: 1 allows the PC to change (advance or redirect); 0 freezes the PC.
- `IF_ID_write` in 1: 1 allows the IF/ID register to update; 0 holds it.
- `pc_src` in 2: next-PC select. `00` = sequential, `01` = `branch_target`, `10` = `jump_target`, `11` = `jr_target`.
- `branch_target`, `jump_target`, `jr_target` in 32 each: redirect addresses from ID.
- `if_flush` in 1: replace the IF/ID contents with a bubble.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; held stable while `imem_req && !imem_ready`.
- `imem_ready` in 1: memory accepts and returns data in the same cycle.
- `imem_rdata` in 32: instruction word, valid when `imem_req && imem_ready`.
- `pc` out 32: current fetch PC.
- `IF_ID_instr` out 32, `IF_ID_pc_plus4` out 32, `IF_ID_valid` out 1: IF/ID register outputs.

## Operation
- A **redirect** occurs in any cycle with `pc_write && pc_src != 00`. Its target is selected by `pc_src`.
- A **completion** occurs in any cycle with `imem_req && imem_ready`.
- **FETCH** (`imem_req=1`, `imem_addr=pc`):
  - Completion and redirect: drop the response; `pc <= target`; stay in FETCH.
  - Completion, no redirect, `IF_ID_write=1`: load IF/ID with `imem_rdata`, `pc+4`, valid=1. If `pc_write`, `pc <= pc+4`. Stay in FETCH.
  - Completion, no redirect, `IF_ID_write=0`: capture `imem_rdata` into the hold buffer; pc unchanged; go to STALL.
  - No completion, redirect: `redir_pc <= target`; go to DRAIN.
- **DRAIN** (`imem_req=1`, `imem_addr=pc` unchanged):
  - A new redirect overwrites `redir_pc`.
  - On completion: drop the response; `pc <=` the newest target (a same-cycle redirect wins over `redir_pc`); go to FETCH.
- **STALL** (`imem_req=0`):
  - Redirect: discard the buffer; `pc <= target`; go to FETCH.
  - Else, `IF_ID_write=1`: load IF/ID from the buffer (valid=1); if `pc_write`, `pc <= pc+4`; go to FETCH.
- **IF/ID register update priority**, evaluated only when `IF_ID_write=1`:
  1. `if_flush`: `IF_ID_instr=0` (NOP), valid=0.
  2. Delivered instruction, per the state rules above.
  3. Otherwise a bubble: instr=0, valid=0.
- When `IF_ID_write=0`, all IF/ID outputs hold, including during flush or redirect.
- A dropped response never reaches IF/ID.
- `pc+4` arithmetic is 32-bit modulo; `32'hFFFF_FFFC` wraps to `32'h0000_0000`.
- `pc_src` is ignored when `pc_write=0`. A redirect with `pc_write=0` is lost; ID must hold it until `pc_write=1`.

## Timing
- Reset values:
  - `pc = RESET_PC`, state = FETCH.
  - `IF_ID_instr = 0`, `IF_ID_pc_plus4 = 0`, `IF_ID_valid = 0`.
  - Hold buffer and `redir_pc` cleared to 0.
  - `imem_req` is forced to 0 while `rst=1`, and is 1 in the first cycle after release.
- Reset mid-transaction abandons the outstanding request; the memory must tolerate a withdrawn `imem_req`.
- Zero-wait memory (`imem_ready=1` every cycle): one instruction per cycle. A request completed in cycle n appears on IF/ID in cycle n+1.
- N-cycle wait: IF/ID carries bubbles for the wait cycles; throughput is 1/(N+1).
- Redirect penalty: the first target instruction is requested in the cycle after the redirect (FETCH/STALL), or in the cycle after the drained completion (DRAIN).
- `imem_req`, `imem_addr` and `pc` are decoded from registered state and pc. There is no combinational path from `imem_ready` to `imem_req`/`imem_addr`.

## Structure
- Package `mips_pkg`:
  - `pc_src_t` enum: `PC_SEQ`, `PC_BRANCH`, `PC_JUMP`, `PC_JR`.
  - `fetch_state_t` enum: `FETCH`, `DRAIN`, `STALL`.
  - `NOP_INSTR = 32'h0000_0000`.
  - Default `RESET_PC`.
- Sub-module `if_id_reg`: write-enable, flush, load instr/pc_plus4/valid, synchronous reset. It is reused by the other pipeline registers' style.
- PC, FSM, hold buffer and `redir_pc` live in `fetch_stage`.

## Test plan
- Zero-wait memory, no stalls, reset release: IF/ID shows addresses 0, 4, 8, 12 with `IF_ID_pc_plus4` 4, 8, 12, 16 on consecutive cycles, valid=1 from cycle 1.
- Load-use stall: response for pc=8 arrives while `pc_write=IF_ID_write=0` for 2 cycles → STALL, `imem_req=0`, IF/ID held. On release, IF/ID gets instr@8 and the next request is pc=12.
- Branch taken, `pc_src=01`, `branch_target=32'h40`, `if_flush=1`, zero-wait: the same-cycle response is dropped, IF/ID valid=0, and the next request addr is `32'h40`.
- Jump during a 3-cycle wait at pc=20 → DRAIN, `imem_addr` stays 20 until ready, the response is dropped, then a request to `jump_target`. A second redirect in DRAIN wins.
- Sync reset asserted mid-DRAIN: next cycle `pc=RESET_PC`, `IF_ID_valid=0`, `imem_req=0` while `rst=1`.
- PC wrap: `RESET_PC=32'hFFFF_FFFC`, zero-wait → second request addr `32'h0000_0000`, `IF_ID_pc_plus4=0`.
